uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter that shares one UART transmitter among four requesters.
// A winner's byte is registered at the grant edge and strobed with tx_send until the
// transmitter drops tx_ready (accept). The block then waits for tx_ready to return
// (done). If the transmitter never takes the byte within WAIT_LIMIT cycles, the
// transfer is abandoned and the sticky timeout_err flag is set.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   req[3:0]     per-requester transmit request
//   data_in[31:0] requester i byte on bits [8i+7:8i]
//   accept[3:0]  one-cycle pulse when the transmitter takes the granted byte
//   done[3:0]    one-cycle pulse when the granted frame has finished
//   tx_data[7:0] byte presented to the transmitter
//   tx_send      send strobe, high for the whole SEND phase
//   tx_ready     transmitter idle flag (1 = idle)
//   busy         high whenever a transfer is in progress
//   grant[1:0]   current or most recent granted requester
//   timeout_err  sticky abandon flag
//   clear_err    synchronous clear for timeout_err
module uart_tx_arbiter #(
    parameter int unsigned WAIT_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [31:0] data_in,
    output logic [3:0]  accept,
    output logic [3:0]  done,
    output logic [7:0]  tx_data,
    output logic        tx_send,
    input  logic        tx_ready,
    output logic        busy,
    output logic [1:0]  grant,
    output logic        timeout_err,
    input  logic        clear_err
);

    localparam int unsigned CntW = $clog2(WAIT_LIMIT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(WAIT_LIMIT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StWaitDone
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    logic [1:0]      last_q, last_d;
    logic [7:0]      data_q, data_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            set_err;

    logic [1:0]      winner;
    logic [1:0]      idx;
    logic            found;

    // Round-robin search: candidates last+1, last+2, last+3, then last itself.
    always_comb begin
        winner = 2'd0;
        found  = 1'b0;
        idx    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        set_err = 1'b0;
        accept  = '0;
        done    = '0;
        tx_send = 1'b0;

        unique case (state_q)
            StIdle: begin
                // tx_ready low means the line is still owned elsewhere; hold off.
                if (found && tx_ready) begin
                    state_d = StSend;
                    grant_d = winner;
                    data_d  = data_in[{winner, 3'b000} +: 8];
                    cnt_d   = '0;
                end
            end
            StSend: begin
                tx_send = 1'b1;
                if (!tx_ready) begin
                    accept[grant_q] = 1'b1;
                    state_d         = StWaitDone;
                end else if (cnt_q == CntLast) begin
                    set_err = 1'b1;
                    last_d  = grant_q;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (tx_ready) begin
                    done[grant_q] = 1'b1;
                    last_d        = grant_q;
                    state_d       = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Set beats clear when both happen in the same cycle.
        if (set_err) begin
            err_d = 1'b1;
        end else if (clear_err) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            grant_q <= 2'd0;
            last_q  <= 2'd3;
            data_q  <= 8'd0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign tx_data     = data_q;
    assign grant       = grant_q;
    assign timeout_err = err_q;

endmodule
